// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op-codes, FSM states
// and the iteration-count helper.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT      = 4'd0;
    localparam logic [3:0] OP_MULTU     = 4'd1;
    localparam logic [3:0] OP_MADD      = 4'd2;
    localparam logic [3:0] OP_MADDU     = 4'd3;
    localparam logic [3:0] OP_MSUB      = 4'd4;
    localparam logic [3:0] OP_MSUBU     = 4'd5;
    localparam logic [3:0] OP_DIV       = 4'd6;
    localparam logic [3:0] OP_DIVU      = 4'd7;
    localparam logic [3:0] OP_MTHI      = 4'd8;
    localparam logic [3:0] OP_MTLO      = 4'd9;
    localparam logic [3:0] OP_MUL       = 4'd10;
    localparam logic [3:0] OP_NOP_FIRST = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int iter_count(input int dataW, input int radixBits);
        return dataW / radixBits;
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 step: either a shift-add multiply bit or a restoring divide bit,
// operating on the {hi, lo} working pair.
module muldiv_iter_step #(
    parameter int DATA_W = 32
) (
    input  logic              i_div,
    input  logic [DATA_W-1:0] i_hi,
    input  logic [DATA_W-1:0] i_lo,
    input  logic [DATA_W-1:0] i_operand,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_shifted;
    logic              w_fits;
    logic [DATA_W-1:0] w_diff;

    assign w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : '0);
    assign w_shifted = {i_hi, i_lo[DATA_W-1]};
    assign w_fits    = w_shifted >= {1'b0, i_operand};
    // The partial remainder stays below the divisor, so the difference fits DATA_W bits.
    assign w_diff    = w_shifted[DATA_W-1:0] - i_operand;

    always_comb begin
        o_hi = w_sum[DATA_W:1];
        o_lo = {w_sum[0], i_lo[DATA_W-1:1]};
        if (i_div) begin
            o_hi = w_fits ? w_diff : w_shifted[DATA_W-1:0];
            o_lo = {i_lo[DATA_W-2:0], w_fits};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers;
// retires RADIX_BITS bits per cycle through a chain of muldiv_iter_step.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [3:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Flush,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo,
    output logic [DATA_W-1:0] Result
);

    localparam int ITER  = iter_count(DATA_W, RADIX_BITS);
    localparam int CNT_W = $clog2(ITER + 1);

    state_t              r_state;
    state_t              w_stateNext;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_op;
    logic                r_negA;
    logic                r_negB;
    logic                r_bZero;
    logic [DATA_W-1:0]   r_hiWork;
    logic [DATA_W-1:0]   r_loWork;
    logic [DATA_W-1:0]   r_operand;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_result;
    logic                r_done;

    logic                w_accept;
    logic                w_isArith;
    logic                w_isDivOp;
    logic                w_isSignedOp;
    logic                w_negA;
    logic                w_negB;
    logic [DATA_W-1:0]   w_magA;
    logic [DATA_W-1:0]   w_magB;
    logic                w_lastIter;
    logic                w_runDiv;
    logic [2*DATA_W-1:0] w_prodMag;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_hilo;
    logic [2*DATA_W-1:0] w_hiloNext;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_resultNext;
    logic [DATA_W-1:0]   w_chainHi [RADIX_BITS+1];
    logic [DATA_W-1:0]   w_chainLo [RADIX_BITS+1];

    assign w_accept     = (r_state == IDLE) && Start && !Flush;
    assign w_isDivOp    = (Op == OP_DIV) || (Op == OP_DIVU);
    assign w_isArith    = (Op <= OP_DIVU) || (Op == OP_MUL);
    assign w_isSignedOp = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) ||
                          (Op == OP_DIV)  || (Op == OP_MUL);
    assign w_negA       = w_isSignedOp && A[DATA_W-1];
    assign w_negB       = w_isSignedOp && B[DATA_W-1];
    assign w_magA       = w_negA ? -A : A;
    assign w_magB       = w_negB ? -B : B;
    assign w_lastIter   = r_cnt == CNT_W'(ITER - 1);
    assign w_runDiv     = (r_op == OP_DIV) || (r_op == OP_DIVU);

    assign w_chainHi[0] = r_hiWork;
    assign w_chainLo[0] = r_loWork;

    for (genvar g = 0; g < RADIX_BITS; g++) begin : g_step
        muldiv_iter_step #(.DATA_W(DATA_W)) u_step (
            .i_div    (w_runDiv),
            .i_hi     (w_chainHi[g]),
            .i_lo     (w_chainLo[g]),
            .i_operand(r_operand),
            .o_hi     (w_chainHi[g+1]),
            .o_lo     (w_chainLo[g+1])
        );
    end

    // Magnitude results are re-signed here; remainder follows the dividend's sign.
    assign w_prodMag = {r_hiWork, r_loWork};
    assign w_prod    = (r_negA ^ r_negB) ? -w_prodMag : w_prodMag;
    assign w_hilo    = {r_hi, r_lo};
    assign w_quot    = (r_negA ^ r_negB) ? -r_loWork : r_loWork;
    assign w_rem     = r_negA ? -r_hiWork : r_hiWork;

    always_comb begin
        w_hiloNext   = w_hilo;
        w_resultNext = r_result;
        case (r_op)
            OP_MULT, OP_MULTU: w_hiloNext = w_prod;
            OP_MADD, OP_MADDU: w_hiloNext = w_hilo + w_prod;
            OP_MSUB, OP_MSUBU: w_hiloNext = w_hilo - w_prod;
            OP_DIV,  OP_DIVU:  w_hiloNext = {w_rem, r_bZero ? {DATA_W{1'b1}} : w_quot};
            OP_MUL:            w_resultNext = w_prod[DATA_W-1:0];
            default:           w_hiloNext = w_hilo;
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE: if (w_accept && w_isArith) w_stateNext = CALC;
            CALC: begin
                if (Flush)           w_stateNext = IDLE;
                else if (w_lastIter) w_stateNext = FIX;
            end
            FIX:     w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_stateNext;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_negA    <= 1'b0;
            r_negB    <= 1'b0;
            r_bZero   <= 1'b0;
            r_hiWork  <= '0;
            r_loWork  <= '0;
            r_operand <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && w_isArith) begin
                        r_op      <= Op;
                        r_cnt     <= '0;
                        r_negA    <= w_negA;
                        r_negB    <= w_negB;
                        r_bZero   <= B == '0;
                        r_hiWork  <= '0;
                        r_loWork  <= w_isDivOp ? w_magA : w_magB;
                        r_operand <= w_isDivOp ? w_magB : w_magA;
                    end else if (w_accept && Op == OP_MTHI) begin
                        r_hi   <= A;
                        r_done <= 1'b1;
                    end else if (w_accept && Op == OP_MTLO) begin
                        r_lo   <= A;
                        r_done <= 1'b1;
                    end
                end
                CALC: begin
                    if (!Flush) begin
                        r_hiWork <= w_chainHi[RADIX_BITS];
                        r_loWork <= w_chainLo[RADIX_BITS];
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!Flush) begin
                        r_hi     <= w_hiloNext[2*DATA_W-1:DATA_W];
                        r_lo     <= w_hiloNext[DATA_W-1:0];
                        r_result <= w_resultNext;
                        r_done   <= 1'b1;
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign Busy   = r_state != IDLE;
    assign Done   = r_done;
    assign Hi     = r_hi;
    assign Lo     = r_lo;
    assign Result = r_result;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Executes the multi-cycle operations MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU/MUL/MTHI/MTLO in the EX stage. Exposes Busy so hazard logic can stall dependent MFHI/MFLO and further muldiv issues. Generalises the fixed 32-bit single-cycle MADD/MSUB/MUL handling to a configurable width and a configurable number of bits retired per cycle.

Parameters:
DATA_W, 32, operand/HI/LO width.
RADIX_BITS, 1, bits retired per iteration (1, 2 or 4); DATA_W % RADIX_BITS must be 0.

Ports:
Clk  input  1  clock, rising edge.
Rst  input  1  synchronous, active-high reset.
Start  input  1  issue strobe, sampled when Busy=0 and Flush=0.
Op  input  4  operation code, encoding from muldiv_pkg.
A  input  DATA_W  rs operand (dividend / multiplicand / MTHI-MTLO source).
B  input  DATA_W  rt operand (divisor / multiplier).
Flush  input  1  abort the in-flight op (exception / branch squash).
Busy  output  1  state != IDLE.
Done  output  1  one-cycle pulse; HI/LO (or Result) updated on this cycle.
Hi  output  DATA_W  HI register.
Lo  output  DATA_W  LO register.
Result  output  DATA_W  low DATA_W bits of the product for MUL; valid while Done=1.

Behaviour:
- Reset: state=IDLE; Busy=0, Done=0, Hi=0, Lo=0, Result=0. Rst mid-operation aborts it; no HI/LO write.
- Op encoding: 0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU, 8 MTHI, 9 MTLO, 10 MUL, 11-15 NOP. Start with NOP is ignored.
- ITER = DATA_W/RADIX_BITS.
- FSM states: IDLE, CALC, FIX.
  - IDLE -> CALC on an accepted arithmetic Start; operands are captured as magnitudes plus sign flags.
  - CALC: ITER cycles of shift-add (mul) or restoring subtract (div), each retiring RADIX_BITS bits.
  - CALC -> FIX after ITER cycles.
  - FIX applies sign correction and MADD/MSUB accumulation, writes HI/LO, then goes to IDLE.
- Latency: Start sampled at edge E0. Busy=1 from E0 to E0+ITER+1. At edge E0+ITER+1, HI/LO are written and Done=1 for exactly one cycle; Busy is already 0 in that cycle.
- MTHI/MTLO: single cycle, no Busy. Hi (resp. Lo) <= A at the sampling edge; Done pulses the next cycle.
- Start while Busy: ignored entirely, including MTHI/MTLO. The hazard unit must hold the instruction.
- Flush: when Busy, go to IDLE at the next edge with no HI/LO write and no Done. Flush has priority over a same-cycle Start, which is dropped.
- Multiply: full 2*DATA_W product, signed or unsigned per op.
  - MADD/MSUB: {Hi,Lo} +/- product, modulo 2^(2*DATA_W).
  - MUL: Result = low half of the signed product; Hi/Lo unchanged.
- Divide:
  - Quotient to Lo, truncated toward zero; remainder to Hi, with the sign of the dividend.
  - B=0: Lo = all ones, Hi = A (no trap).
  - Signed MIN / -1: Lo = MIN, Hi = 0.
  - Divide-by-zero and overflow still take the full latency.
- Hi/Lo change only on FIX completion or MTHI/MTLO.

Decomposition:
- muldiv_pkg holds:
  - the op-code localparams (OP_MULT..OP_MUL, OP_NOP range);
  - the state encoding (IDLE, CALC, FIX);
  - a helper function for ITER.
- Sub-module muldiv_iter_step: combinational single-radix step covering one shift-add and one restoring-subtract bit. It is instantiated RADIX_BITS times in a chain inside hilo_muldiv_unit.

Test Plan:
- DATA_W=32, RADIX_BITS=1: MULT A=0xFFFFFFFD, B=7 -> Busy high 33 cycles; Done at E0+33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- MTHI A=0x1; MTLO A=0xFFFFFFFF; MADDU A=1, B=1 -> Hi=0x00000002, Lo=0x00000000. Then MSUB A=2, B=1 -> Hi=0x1, Lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=7, B=0 -> Lo=0xFFFFFFFF, Hi=7. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MULT started, Flush at cycle 10 -> Busy=0 next cycle, no Done, Hi/Lo unchanged. Start+Flush in the same idle cycle -> dropped. Start next cycle -> accepted.
- MTHI issued while Busy -> Hi unchanged after completion. Rst at cycle 5 of a DIV -> Hi=Lo=0, Busy=0, Done never pulses.
- RADIX_BITS=4: MULTU 0xFFFFFFFF*0xFFFFFFFF -> Done at E0+9, Hi=0xFFFFFFFE, Lo=0x00000001. MUL A=-4, B=5 -> Result=0xFFFFFFEC, Hi/Lo unchanged.
